// File: rtl/param_acc_processor_pkg.sv
// rtl/param_acc_processor_pkg.sv - opcode and sequencer state definitions for the accumulator processor
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    IN    = 3'd2,
    OUT   = 3'd3,
    HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/param_acc_processor_if.sv
// rtl/param_acc_processor_if.sv - fetch, stream and status bundle of the accumulator processor
interface param_acc_processor_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int INSTR_W = 4 + ADDR_W;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [ADDR_W-1:0]  pc;
  logic               halted;

  // processor side
  modport master (
    output imem_req, imem_addr, in_ready, out_valid, out_data, pc, halted,
    input  imem_ack, imem_rdata, in_valid, in_data, out_ready
  );

  // instruction memory / stream fabric side
  modport slave (
    input  imem_req, imem_addr, in_ready, out_valid, out_data, pc, halted,
    output imem_ack, imem_rdata, in_valid, in_data, out_ready
  );
endinterface

// File: rtl/param_acc_processor_alu.sv
// rtl/param_acc_processor_alu.sv - combinational ALU producing result, carry/borrow and zero
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // the extra top bit of the difference is the borrow (acc < operand)
  assign sum  = {1'b0, acc_i} + {1'b0, operand_i};
  assign diff = {1'b0, acc_i} - {1'b0, operand_i};

  // result select; carry only matters for ADD/SUB, the top decides what to commit
  always_comb begin
    result_o = acc_i;
    carry_o  = 1'b0;
    case (op_i)
      OP_LDI, OP_LD: result_o = operand_i;
      OP_ADD: begin
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        result_o = diff[DATA_W-1:0];
        carry_o  = diff[DATA_W];
      end
      OP_AND: result_o = acc_i & operand_i;
      OP_OR:  result_o = acc_i | operand_i;
      OP_XOR: result_o = acc_i ^ operand_i;
      default: result_o = acc_i;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/param_acc_processor.sv
// rtl/param_acc_processor.sv - multi-cycle accumulator processor with data RAM and stream I/O
module param_acc_processor
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  param_acc_processor_if.master  bus
);
  localparam int INSTR_W = 4 + ADDR_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d, c_q, c_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   addr_a;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry, alu_zero;
  logic                mem_we;

  assign opcode  = ir_q[INSTR_W-1 -: 4];
  assign addr_a  = ir_q[ADDR_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign operand = (opcode == OP_LDI) ? DATA_W'(addr_a) : mem[addr_a];

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i      (opcode),
    .acc_i     (acc_q),
    .operand_i (operand),
    .result_o  (alu_result),
    .carry_o   (alu_carry),
    .zero_o    (alu_zero)
  );

  // sequencer: next state, pc, accumulator, flags and output-stream registers
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    z_d         = z_q;
    c_d         = c_q;
    ir_d        = ir_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem_we      = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_LDI, OP_LD, OP_AND, OP_OR, OP_XOR: begin
            acc_d = alu_result;
            z_d   = alu_zero;
          end
          OP_ADD, OP_SUB: begin
            acc_d = alu_result;
            z_d   = alu_zero;
            c_d   = alu_carry;
          end
          OP_ST:  mem_we = 1'b1;
          OP_IN: begin
            pc_d    = pc_q;
            state_d = IN;
          end
          OP_OUT: begin
            pc_d        = pc_q;
            state_d     = OUT;
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
          end
          OP_JMP: pc_d = addr_a;
          OP_JZ:  if (z_q) pc_d = addr_a;
          OP_JC:  if (c_q) pc_d = addr_a;
          OP_HLT: state_d = HALT;
          OP_NOP, OP_RSV: state_d = FETCH;
          default: state_d = FETCH;
        endcase
      end
      IN: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          z_d     = (bus.in_data == '0);
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // architectural state; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      acc_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      ir_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      c_q         <= c_d;
      ir_q        <= ir_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // data RAM is not reset; a store lands before the following EXEC can read it
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_a] <= acc_q;
  end

  assign bus.imem_req  = (state_q == FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.in_ready  = (state_q == IN);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.pc        = pc_q;
  assign bus.halted    = (state_q == HALT);
endmodule

// File: tb/tb_param_acc_processor.sv
// tb/tb_param_acc_processor.sv - self-checking bench for param_acc_processor
module tb_param_acc_processor;
  import acc_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ack_ok = 1'b0;
  logic ack_force = 1'b0;
  int errors = 0;
  int checks = 0;

  logic [11:0] prog [256];
  logic [7:0]  in_vals [$];
  int got_fetch [$];
  int got_out [$];
  int exp_fetch [$];
  int exp_out [$];
  int exp_pc;
  int exp_in_used;
  int in_idx;

  always #5 clk = ~clk;

  param_acc_processor_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  param_acc_processor #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_rdata = prog[bus.imem_addr];
  assign bus.imem_ack   = (bus.imem_req & ack_ok) | ack_force;

  function automatic logic [11:0] ins(input logic [3:0] op, input int a);
    return {op, 8'(a)};
  endfunction

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = {OP_HLT, 8'h00};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ack_ok = 1'b0;
    ack_force = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // drives handshakes until HALT or budget; logs fetches, outputs and consumed inputs
  task automatic run_prog(input int max_cycles, input bit rand_hs, output bit halted_seen);
    bit hold;
    int held;
    got_fetch.delete();
    got_out.delete();
    in_idx = 0;
    hold = 1'b0;
    held = 0;
    halted_seen = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      ack_ok = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid = rand_hs ? ($urandom_range(0, 2) == 0) : 1'b1;
      bus.in_data = (in_idx < in_vals.size()) ? in_vals[in_idx] : 8'h00;
      bus.out_ready = rand_hs ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      if (bus.halted) begin
        halted_seen = 1'b1;
        break;
      end
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_data) !== held) begin
          errors++;
          $display("FAIL out_hold: valid=%0b data=%02h required valid=1 data=%02h", bus.out_valid, bus.out_data, held);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held = int'(bus.out_data);
      if (bus.imem_req && bus.imem_ack) got_fetch.push_back(int'(bus.imem_addr));
      if (bus.in_valid && bus.in_ready) in_idx++;
      if (bus.out_valid && bus.out_ready) got_out.push_back(int'(bus.out_data));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // instruction-level reference: executes prog with plain integer arithmetic
  task automatic model_run();
    int pc, acc, z, c, npc, in_i, op, a, m, t;
    int mem [256];
    pc = 0; acc = 0; z = 0; c = 0; in_i = 0;
    foreach (mem[i]) mem[i] = 0;
    exp_fetch.delete();
    exp_out.delete();
    exp_pc = -1;
    exp_in_used = 0;
    for (int step = 0; step < 1000; step++) begin
      op = int'(prog[pc][11:8]);
      a = int'(prog[pc][7:0]);
      m = mem[a];
      exp_fetch.push_back(pc);
      npc = (pc + 1) % 256;
      case (op)
        1: acc = a;
        2: acc = m;
        3: mem[a] = acc;
        4: begin t = acc + m; c = (t > 255) ? 1 : 0; acc = t % 256; end
        5: begin c = (acc < m) ? 1 : 0; acc = (acc - m + 256) % 256; end
        6: acc = acc & m;
        7: acc = acc | m;
        8: acc = acc ^ m;
        9: begin acc = int'(in_vals[in_i]); in_i++; end
        10: exp_out.push_back(acc);
        11: npc = a;
        12: if (z != 0) npc = a;
        13: if (c != 0) npc = a;
        15: begin exp_pc = npc; exp_in_used = in_i; return; end
        default: ;
      endcase
      if (op == 1 || op == 2 || (op >= 4 && op <= 9)) z = (acc == 0) ? 1 : 0;
      pc = npc;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.pc !== 8'h00 || bus.halted !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: pc=%02h halted=%0b out_valid=%0b out_data=%02h required 00/0/0/00", bus.pc, bus.halted, bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: req=%0b addr=%02h in_ready=%0b required 1/00/0", bus.imem_req, bus.imem_addr, bus.in_ready);
    end
  endtask

  task automatic test_add_carry();
    bit hs;
    int exp_f [8] = '{0, 1, 2, 3, 4, 5, 6, 'h30};
    clear_prog();
    prog[0] = ins(OP_LDI, 'hF0); prog[1] = ins(OP_ST, 'h10);
    prog[2] = ins(OP_LDI, 'h20); prog[3] = ins(OP_ADD, 'h10);
    prog[4] = ins(OP_OUT, 0);    prog[5] = ins(OP_JZ, 'h20);
    prog[6] = ins(OP_JC, 'h30);
    do_reset();
    run_prog(200, 1'b0, hs);
    checks++;
    if (!hs || got_out.size() != 1 || got_out[0] != 'h10) begin
      errors++;
      $display("FAIL add_carry_out: halted=%0b outs=%0d first=%02h required 1/1/10", hs, got_out.size(), (got_out.size() > 0) ? got_out[0] : -1);
    end
    checks++;
    if (got_fetch.size() != 8) begin
      errors++;
      $display("FAIL add_carry_len: fetches=%0d required 8", got_fetch.size());
    end else begin
      foreach (exp_f[i]) if (got_fetch[i] != exp_f[i]) begin
        errors++;
        $display("FAIL add_carry_trace: fetch[%0d]=%02h required %02h", i, got_fetch[i], exp_f[i]);
        break;
      end
    end
    checks++;
    if (bus.pc !== 8'h31) begin
      errors++;
      $display("FAIL add_carry_pc: pc=%02h required 31", bus.pc);
    end
  endtask

  task automatic test_sub_zero();
    bit hs;
    int exp_f [7] = '{0, 1, 2, 3, 'h40, 'h41, 'h42};
    clear_prog();
    prog[0] = ins(OP_LDI, 3);      prog[1] = ins(OP_ST, 'h11);
    prog[2] = ins(OP_SUB, 'h11);   prog[3] = ins(OP_JZ, 'h40);
    prog['h40] = ins(OP_JC, 'h50); prog['h41] = ins(OP_OUT, 0);
    do_reset();
    run_prog(200, 1'b1, hs);
    checks++;
    if (!hs || got_out.size() != 1 || got_out[0] != 0) begin
      errors++;
      $display("FAIL sub_zero_out: halted=%0b outs=%0d first=%02h required 1/1/00", hs, got_out.size(), (got_out.size() > 0) ? got_out[0] : -1);
    end
    checks++;
    if (got_fetch.size() != 7) begin
      errors++;
      $display("FAIL sub_zero_len: fetches=%0d required 7", got_fetch.size());
    end else begin
      foreach (exp_f[i]) if (got_fetch[i] != exp_f[i]) begin
        errors++;
        $display("FAIL sub_zero_trace: fetch[%0d]=%02h required %02h", i, got_fetch[i], exp_f[i]);
        break;
      end
    end
  endtask

  task automatic test_stream();
    bit seen;
    clear_prog();
    prog[0] = ins(OP_IN, 0); prog[1] = ins(OP_OUT, 0);
    do_reset();
    ack_ok = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus.in_ready;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stream_in_ready: in_ready never rose, required 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.pc !== 8'h00) begin
        errors++;
        $display("FAIL stream_in_wait: in_ready=%0b pc=%02h required 1/00", bus.in_ready, bus.pc);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1 seen = bus.out_valid;
      if (!seen) @(negedge clk);
    end
    checks++;
    if (!seen || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL stream_out_first: valid=%0b data=%02h required 1/a5", seen, bus.out_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
        errors++;
        $display("FAIL stream_out_hold: valid=%0b data=%02h required 1/a5", bus.out_valid, bus.out_data);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_out_drop: valid=%0b required 0", bus.out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus.halted;
    end
    checks++;
    if (!seen || bus.pc !== 8'h03) begin
      errors++;
      $display("FAIL stream_end: halted=%0b pc=%02h required 1/03", seen, bus.pc);
    end
  endtask

  task automatic test_pc_wrap();
    bit hs;
    int exp_f [8] = '{0, 1, 2, 3, 4, 'hFF, 0, 5};
    clear_prog();
    prog[0] = ins(OP_JC, 5);     prog[1] = ins(OP_LDI, 'hFF);
    prog[2] = ins(OP_ST, 0);     prog[3] = ins(OP_ADD, 0);
    prog[4] = ins(OP_JMP, 'hFF); prog['hFF] = ins(OP_NOP, 0);
    do_reset();
    run_prog(300, 1'b1, hs);
    checks++;
    if (!hs || got_fetch.size() != 8) begin
      errors++;
      $display("FAIL wrap_len: halted=%0b fetches=%0d required 1/8", hs, got_fetch.size());
    end else begin
      foreach (exp_f[i]) if (got_fetch[i] != exp_f[i]) begin
        errors++;
        $display("FAIL wrap_trace: fetch[%0d]=%02h required %02h", i, got_fetch[i], exp_f[i]);
        break;
      end
    end
  endtask

  task automatic test_halt_hold();
    bit hs;
    clear_prog();
    prog[0] = ins(OP_LDI, 5);
    do_reset();
    run_prog(100, 1'b0, hs);
    checks++;
    if (!hs || bus.pc !== 8'h02) begin
      errors++;
      $display("FAIL halt_entry: halted=%0b pc=%02h required 1/02", hs, bus.pc);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ack_force = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.pc !== 8'h02 || bus.halted !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold: req=%0b pc=%02h halted=%0b in_ready=%0b required 0/02/1/0", bus.imem_req, bus.pc, bus.halted, bus.in_ready);
      end
    end
    ack_force = 1'b0;
  endtask

  task automatic test_reset_mid_out();
    bit seen;
    clear_prog();
    prog[0] = ins(OP_LDI, 'h77); prog[1] = ins(OP_OUT, 0);
    do_reset();
    ack_ok = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus.out_valid;
    end
    checks++;
    if (!seen || bus.out_data !== 8'h77) begin
      errors++;
      $display("FAIL rst_out_setup: valid=%0b data=%02h required 1/77", seen, bus.out_data);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.pc !== 8'h00 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: valid=%0b pc=%02h data=%02h required 0/00/00", bus.out_valid, bus.pc, bus.out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_refetch: req=%0b addr=%02h required 1/00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random_programs();
    bit hs;
    int p, op, a, bad;
    for (int n = 0; n < 6; n++) begin
      clear_prog();
      p = 0;
      for (int k = 0; k < 8; k++) begin
        prog[p] = ins(OP_LDI, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255)); p++;
        prog[p] = ins(OP_ST, k); p++;
      end
      for (int k = 0; k < int'($urandom_range(20, 40)); k++) begin
        op = $urandom_range(0, 14);
        if (op == 11 || op == 12 || op == 13) a = p + 1 + $urandom_range(0, 3);
        else if (op == 1) a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
        else a = $urandom_range(0, 7);
        prog[p] = ins(4'(op), a);
        p++;
      end
      in_vals.delete();
      for (int k = 0; k < 64; k++) in_vals.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
      model_run();
      do_reset();
      run_prog(4000, 1'b1, hs);
      checks++;
      if (!hs) begin
        errors++;
        $display("FAIL rand%0d_halt: halted=0 within budget required 1", n);
      end
      bad = -1;
      if (got_fetch.size() == exp_fetch.size())
        foreach (exp_fetch[i]) if (bad < 0 && got_fetch[i] != exp_fetch[i]) bad = i;
      checks++;
      if (got_fetch.size() != exp_fetch.size() || bad >= 0) begin
        errors++;
        $display("FAIL rand%0d_fetch: len=%0d first_diff=%0d required len=%0d", n, got_fetch.size(), bad, exp_fetch.size());
      end
      bad = -1;
      if (got_out.size() == exp_out.size())
        foreach (exp_out[i]) if (bad < 0 && got_out[i] != exp_out[i]) bad = i;
      checks++;
      if (got_out.size() != exp_out.size() || bad >= 0) begin
        errors++;
        $display("FAIL rand%0d_out: len=%0d first_diff=%0d required len=%0d", n, got_out.size(), bad, exp_out.size());
      end
      checks++;
      if (int'(bus.pc) != exp_pc || in_idx != exp_in_used) begin
        errors++;
        $display("FAIL rand%0d_final: pc=%02h inputs=%0d required pc=%02h inputs=%0d", n, bus.pc, in_idx, exp_pc, exp_in_used);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    clear_prog();
    test_reset();
    test_add_carry();
    test_sub_zero();
    test_stream();
    test_pc_wrap();
    test_halt_hold();
    test_reset_mid_out();
    test_random_programs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
